// File: rtl/icache_fetch_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_fetch_pkg : shared bus widths and FSM encoding for the fetch cache
// Revision: 1.0
// ---------------------------------------------------------------------------
package icache_fetch_pkg;

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_W      = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } icache_state_e;

endpackage
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_array : valid/tag/data storage, async read by index, sync write
// Revision: 1.0
// ---------------------------------------------------------------------------
module icache_array #(
  parameter int INDEX_BITS = 7,
  parameter int TAG_W      = 23,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] lookup_index,
  input  logic [TAG_W-1:0]      lookup_tag,
  output logic                  hit,
  output logic [DATA_W-1:0]     rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_W-1:0]     wr_data
);

  localparam int LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tags  [LINES];
  logic [DATA_W-1:0] words [LINES];

  // Only the valid bits need reset; stale tag/data behind a clear bit is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_index]  <= wr_tag;
      words[wr_index] <= wr_data;
    end
  end

  assign hit     = valid[lookup_index] && (tags[lookup_index] == lookup_tag);
  assign rd_data = words[lookup_index];

endmodule
`default_nettype wire

// File: rtl/icache_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// icache_fetch : direct-mapped one-word-line I-cache; ICACHE_PERF_EN adds
//                hit/miss counters. Revision: 1.0
// ---------------------------------------------------------------------------
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int INDEX_BITS = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              if_ready,
  output logic [MEM_W-1:0]  if_inst,
  output logic [ADDR_W-1:0] if_inst_pc,
  output logic              mc_read,
  output logic [ADDR_W-1:0] mc_addr,
  output logic              mc_discard,
  input  logic              mc_ready,
  input  logic [MEM_W-1:0]  mc_data,
  input  logic [ADDR_W-1:0] mc_addr_o,
  output logic [31:0]       perf_hit,
  output logic [31:0]       perf_miss
);

  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  icache_state_e     state;
  icache_state_e     state_nx;
  logic [ADDR_W-1:0] miss_addr;
  logic [ADDR_W-1:0] pc_aligned;
  logic              hit;
  logic [MEM_W-1:0]  rd_data;
  logic              fill_match;
  logic              fill_we;
  logic              fill_resp;
  logic              hit_lookup;
  logic              start_miss;
  logic              unused_pc_bits;

  assign pc_aligned     = {if_pc[ADDR_W-1:2], 2'b00};
  assign unused_pc_bits = ^if_pc[1:0];
  assign fill_match     = mc_ready && (mc_addr_o == miss_addr);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W),
    .DATA_W     (MEM_W)
  ) u_array (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_index (if_pc[INDEX_BITS+1:2]),
    .lookup_tag   (if_pc[ADDR_W-1:INDEX_BITS+2]),
    .hit          (hit),
    .rd_data      (rd_data),
    .we           (fill_we),
    .wr_index     (miss_addr[INDEX_BITS+1:2]),
    .wr_tag       (miss_addr[ADDR_W-1:INDEX_BITS+2]),
    .wr_data      (mc_data)
  );

  always_comb begin
    state_nx   = state;
    hit_lookup = 1'b0;
    start_miss = 1'b0;
    fill_resp  = 1'b0;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (if_req) begin
            if (hit) begin
              state_nx   = RESP;
              hit_lookup = 1'b1;
            end else begin
              state_nx   = MISS;
              start_miss = 1'b1;
            end
          end
        end
        MISS: begin
          if (fill_match) begin
            state_nx  = RESP;
            fill_resp = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // A matching fill is kept even when a flush drops the response.
  assign fill_we    = rdy && (state == MISS) && fill_match;
  assign mc_read    = (state == MISS);
  assign mc_addr    = miss_addr;
  assign mc_discard = rdy && flush && (state == MISS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      miss_addr  <= '0;
      if_ready   <= 1'b0;
      if_inst    <= '0;
      if_inst_pc <= '0;
    end else if (rdy) begin
      state    <= state_nx;
      if_ready <= (state_nx == RESP);
      if (start_miss) begin
        miss_addr <= pc_aligned;
      end
      if (hit_lookup) begin
        if_inst    <= rd_data;
        if_inst_pc <= pc_aligned;
      end else if (fill_resp) begin
        if_inst    <= mc_data;
        if_inst_pc <= miss_addr;
      end
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (rdy) begin
      if (hit_lookup) hit_cnt  <= hit_cnt + 32'd1;
      if (start_miss) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign perf_hit  = hit_cnt;
  assign perf_miss = miss_cnt;
`else
  assign perf_hit  = '0;
  assign perf_miss = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_icache_fetch : directed self-checking bench for icache_fetch
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_icache_fetch;

`ifdef ICACHE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_pc = '0;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_inst_pc;
  logic        mc_read;
  logic [31:0] mc_addr;
  logic        mc_discard;
  logic        mc_ready = 1'b0;
  logic [31:0] mc_data = '0;
  logic [31:0] mc_addr_o = '0;
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;

  int checks = 0;
  int failures = 0;
  int read_starts = 0;
  logic rd_prev = 1'b0;

  icache_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rdy        (rdy),
    .flush      (flush),
    .if_req     (if_req),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .if_inst    (if_inst),
    .if_inst_pc (if_inst_pc),
    .mc_read    (mc_read),
    .mc_addr    (mc_addr),
    .mc_discard (mc_discard),
    .mc_ready   (mc_ready),
    .mc_data    (mc_data),
    .mc_addr_o  (mc_addr_o),
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mc_read && !rd_prev) read_starts++;
    rd_prev = mc_read;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_reply(input logic [31:0] a, input logic [31:0] d);
    mc_ready = 1'b1; mc_addr_o = a; mc_data = d;
    cycle();
    mc_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    checks++; if ({if_ready, mc_read, mc_discard} !== 3'b000) begin failures++; $display("FAIL rst_ctrl: got %b want 000", {if_ready, mc_read, mc_discard}); end
    checks++; if ({if_inst, if_inst_pc, mc_addr} !== 96'd0) begin failures++; $display("FAIL rst_data: got %h want 0", {if_inst, if_inst_pc, mc_addr}); end
    checks++; if ({perf_hit, perf_miss} !== 64'd0) begin failures++; $display("FAIL rst_perf: got %h want 0", {perf_hit, perf_miss}); end
    rst_n = 1'b1;
    cycle();
  endtask

  task automatic test_cold_miss();
    if_req = 1'b1; if_pc = 32'h0;
    cycle();
    checks++; if ({mc_read, if_ready} !== 2'b10) begin failures++; $display("FAIL cold_issue: got %b want 10", {mc_read, if_ready}); end
    checks++; if (mc_addr !== 32'h0) begin failures++; $display("FAIL cold_addr: got %h want 0", mc_addr); end
    cycle();
    mem_reply(32'h0, 32'h0000_0013);
    if_req = 1'b0;
    checks++; if ({if_ready, mc_read} !== 2'b10) begin failures++; $display("FAIL cold_resp: got %b want 10", {if_ready, mc_read}); end
    checks++; if ({if_inst, if_inst_pc} !== {32'h13, 32'h0}) begin failures++; $display("FAIL cold_data: got %h want 00000013_00000000", {if_inst, if_inst_pc}); end
    cycle();
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL cold_pulse: got %b want 0", if_ready); end
    checks++; if (read_starts !== 1) begin failures++; $display("FAIL cold_reads: got %0d want 1", read_starts); end
  endtask

  task automatic test_hit();
    int rs = read_starts;
    if_req = 1'b1; if_pc = 32'h0;
    cycle();
    if_req = 1'b0;
    checks++; if ({if_ready, mc_read} !== 2'b10) begin failures++; $display("FAIL hit_resp: got %b want 10", {if_ready, mc_read}); end
    checks++; if ({if_inst, if_inst_pc} !== {32'h13, 32'h0}) begin failures++; $display("FAIL hit_data: got %h want 00000013_00000000", {if_inst, if_inst_pc}); end
    cycle();
    checks++; if (read_starts !== rs) begin failures++; $display("FAIL hit_noread: got %0d want %0d", read_starts, rs); end
    checks++; if ({perf_hit, perf_miss} !== (PERF ? {32'd1, 32'd1} : 64'd0)) begin failures++; $display("FAIL hit_perf: got %0d/%0d want %0d/%0d", perf_hit, perf_miss, PERF, PERF); end
  endtask

  task automatic test_conflict();
    if_req = 1'b1; if_pc = 32'h200;
    cycle();
    checks++; if ({mc_read, mc_addr} !== {1'b1, 32'h200}) begin failures++; $display("FAIL conf_miss1: got %b/%h want 1/00000200", mc_read, mc_addr); end
    mem_reply(32'h200, 32'h0000_0293);
    if_req = 1'b0;
    checks++; if ({if_ready, if_inst, if_inst_pc} !== {1'b1, 32'h293, 32'h200}) begin failures++; $display("FAIL conf_resp1: got %b/%h/%h want 1/00000293/00000200", if_ready, if_inst, if_inst_pc); end
    cycle();
    if_req = 1'b1; if_pc = 32'h0;
    cycle();
    checks++; if ({mc_read, if_ready, mc_addr} !== {2'b10, 32'h0}) begin failures++; $display("FAIL conf_miss2: got %b%b/%h want 10/00000000", mc_read, if_ready, mc_addr); end
    mem_reply(32'h0, 32'h0000_0013);
    if_req = 1'b0;
    checks++; if ({if_ready, if_inst} !== {1'b1, 32'h13}) begin failures++; $display("FAIL conf_resp2: got %b/%h want 1/00000013", if_ready, if_inst); end
    cycle();
    checks++; if ({perf_hit, perf_miss} !== (PERF ? {32'd1, 32'd3} : 64'd0)) begin failures++; $display("FAIL conf_perf: got %0d/%0d want 1/3 or 0/0", perf_hit, perf_miss); end
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_pc = 32'h1004;
    cycle();
    flush = 1'b1;
    #1;
    checks++; if ({mc_discard, mc_read} !== 2'b11) begin failures++; $display("FAIL fl_discard: got %b want 11", {mc_discard, mc_read}); end
    cycle();
    flush = 1'b0; if_req = 1'b0;
    checks++; if ({if_ready, mc_read, mc_discard} !== 3'b000) begin failures++; $display("FAIL fl_idle: got %b want 000", {if_ready, mc_read, mc_discard}); end
    // request together with flush must be dropped, even though 0x0 would hit
    if_req = 1'b1; if_pc = 32'h0; flush = 1'b1;
    cycle();
    flush = 1'b0; if_req = 1'b0;
    checks++; if ({if_ready, mc_read} !== 2'b00) begin failures++; $display("FAIL fl_ignore: got %b want 00", {if_ready, mc_read}); end
    if_req = 1'b1; if_pc = 32'h2000;
    cycle();
    mem_reply(32'h1004, 32'hDEAD_BEEF);
    checks++; if ({if_ready, mc_read, mc_addr} !== {2'b01, 32'h2000}) begin failures++; $display("FAIL fl_stale: got %b%b/%h want 01/00002000", if_ready, mc_read, mc_addr); end
    mem_reply(32'h2000, 32'h0000_2013);
    if_req = 1'b0;
    checks++; if ({if_ready, if_inst, if_inst_pc} !== {1'b1, 32'h2013, 32'h2000}) begin failures++; $display("FAIL fl_resp: got %b/%h/%h want 1/00002013/00002000", if_ready, if_inst, if_inst_pc); end
    cycle();
    // flush colliding with the matching fill: line kept, no response
    if_req = 1'b1; if_pc = 32'h3000;
    cycle();
    flush = 1'b1;
    mem_reply(32'h3000, 32'h0000_3013);
    flush = 1'b0; if_req = 1'b0;
    checks++; if ({if_ready, mc_read} !== 2'b00) begin failures++; $display("FAIL fl_fill: got %b want 00", {if_ready, mc_read}); end
    if_req = 1'b1; if_pc = 32'h3000;
    cycle();
    if_req = 1'b0;
    checks++; if ({if_ready, if_inst, mc_read} !== {1'b1, 32'h3013, 1'b0}) begin failures++; $display("FAIL fl_kept: got %b/%h/%b want 1/00003013/0", if_ready, if_inst, mc_read); end
    cycle();
    checks++; if ({perf_hit, perf_miss} !== (PERF ? {32'd2, 32'd6} : 64'd0)) begin failures++; $display("FAIL fl_perf: got %0d/%0d want 2/6 or 0/0", perf_hit, perf_miss); end
  endtask

  task automatic test_rdy_freeze();
    if_req = 1'b1; if_pc = 32'h4000;
    cycle();
    rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checks++; if ({mc_read, if_ready, mc_addr} !== {2'b10, 32'h4000}) begin failures++; $display("FAIL rdy_hold%0d: got %b%b/%h want 10/00004000", i, mc_read, if_ready, mc_addr); end
    end
    checks++; if ({perf_hit, perf_miss} !== (PERF ? {32'd2, 32'd7} : 64'd0)) begin failures++; $display("FAIL rdy_perf: got %0d/%0d want 2/7 or 0/0", perf_hit, perf_miss); end
    rdy = 1'b1;
    mem_reply(32'h4000, 32'h0000_4013);
    if_req = 1'b0;
    checks++; if ({if_ready, if_inst, if_inst_pc} !== {1'b1, 32'h4013, 32'h4000}) begin failures++; $display("FAIL rdy_resp: got %b/%h/%h want 1/00004013/00004000", if_ready, if_inst, if_inst_pc); end
    cycle();
  endtask

  task automatic test_reset_mid_miss();
    if_req = 1'b1; if_pc = 32'h5000;
    cycle();
    checks++; if (mc_read !== 1'b1) begin failures++; $display("FAIL rm_pre: got %b want 1", mc_read); end
    if_req = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if ({mc_read, perf_miss} !== {1'b0, 32'd0}) begin failures++; $display("FAIL rm_async: got %b/%0d want 0/0", mc_read, perf_miss); end
    cycle();
    rst_n = 1'b1;
    cycle();
    if_req = 1'b1; if_pc = 32'h3000;
    cycle();
    checks++; if ({mc_read, if_ready} !== 2'b10) begin failures++; $display("FAIL rm_cold: got %b want 10", {mc_read, if_ready}); end
    mem_reply(32'h3000, 32'h0000_3013);
    if_req = 1'b0;
    checks++; if ({if_ready, if_inst} !== {1'b1, 32'h3013}) begin failures++; $display("FAIL rm_resp: got %b/%h want 1/00003013", if_ready, if_inst); end
    cycle();
    checks++; if ({perf_hit, perf_miss} !== (PERF ? {32'd0, 32'd1} : 64'd0)) begin failures++; $display("FAIL rm_perf: got %0d/%0d want 0/1 or 0/0", perf_hit, perf_miss); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_rdy_freeze();
    test_reset_mid_miss();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
